cic_interp_scheduler: RTL and testbench
=======================================

// Module: cic_interp_scheduler
// PURPOSE
//   Single-clock sequencer for the CIC interpolator datapath. Accepts input samples from
//   upstream over a valid/ready handshake and generates the w_ena write strobe (one per
//   input sample) and the r_ena read strobe with read phase (R per input sample, one
//   every DIV+1 clocks). Sits between the sample source and the interpolator memory/
//   integrator stage, owns the output sample cadence and reports underrun.
// PARAMETERS
//   RATIO_WIDTH  4  width of ratio_i / phase_o; interpolation ratio R up to 2**RATIO_WIDTH-1
//   DIV_WIDTH    8  width of div_i; output strobe period = div_i+1 clocks
// PORTS
//   clk_i          in   1            single clock, all logic rising-edge
//   rst_i          in   1            asynchronous, active-high reset
//   en_i           in   1            global enable; low aborts run, blocks acceptance
//   ratio_i        in   RATIO_WIDTH  interpolation ratio R; 0 treated as 1
//   div_i          in   DIV_WIDTH    output period minus 1, in clocks
//   s_valid_i      in   1            upstream sample valid
//   s_ready_o      out  1            scheduler can accept sample (combinational)
//   w_ena_o        out  1            datapath write strobe = s_valid_i & s_ready_o
//   r_ena_o        out  1            datapath read/output strobe, registered, 1-cycle pulse
//   phase_o        out  RATIO_WIDTH  read phase 0..R-1 qualifying r_ena_o, registered
//   busy_o         out  1            state == RUN
//   underrun_o     out  1            sticky underrun flag
//   underrun_clr_i in   1            clears underrun_o
// BEHAVIOUR
//   - Reset: state=IDLE, loaded=0, div_cnt=0, phase=0, r_ena_o=0, phase_o=0, underrun_o=0.
//     s_ready_o/w_ena_o are 0 while rst_i high. Reset mid-run aborts immediately.
//   - s_ready_o = en_i & !loaded. w_ena_o = s_valid_i & s_ready_o. Handshake completes
//     on any cycle w_ena_o=1. Upstream data is taken by the datapath on that cycle.
//   - loaded: set on w_ena_o. Cleared on a tick with phase==R_lat-1; clear wins over set.
//   - IDLE: counters held at 0. On en_i & (loaded | w_ena_o): latch R_lat=max(ratio_i,1),
//     latch DIV_lat=div_i, go to RUN with div_cnt=0, phase=0.
//   - RUN: div_cnt counts 0..DIV_lat and wraps. tick = (div_cnt==DIV_lat).
//     On tick, phase advances mod R_lat.
//   - Tick at phase 0 requires (loaded | w_ena_o). If the condition is not met, this is
//     an underrun:
//       - underrun_o <= 1
//       - r_ena_o suppressed
//       - state -> IDLE; div_cnt, phase <= 0
//   - Otherwise, on tick: r_ena_o <= 1 and phase_o <= phase on the next edge.
//   - Latency: first r_ena_o occurs DIV_lat+2 clocks after the starting w_ena_o.
//     Thereafter r_ena_o occurs every DIV_lat+1 clocks, and w_ena_o once per R_lat ticks
//     with continuous supply.
//   - en_i low in RUN: next edge state=IDLE, loaded=0, counters 0, no further r_ena_o.
//     A tick in the same cycle is dropped.
//   - ratio_i/div_i changes during RUN are ignored until next IDLE->RUN.
//   - underrun_o cleared by underrun_clr_i; a set in the same cycle wins. Not cleared by en_i.
//   - R_lat=1: the phase-0 and phase-(R-1) rules apply on the same tick.
//     With div=0 this gives continuous w_ena_o and r_ena_o every cycle.
// TESTING
//   1. Reset with en_i=0, s_valid_i=1:
//      all outputs 0, s_ready_o=0, no strobes for 20 cycles.
//   2. R=2, div=3, s_valid_i held 1: w_ena_o at t0, r_ena_o at t0+5,+9,+13,...
//      phase_o 0,1,0,1. w_ena_o every 8 clocks, underrun_o stays 0.
//   3. R=1, div=0, s_valid_i held 1: w_ena_o and r_ena_o both high every cycle
//      after start, phase_o=0, busy_o=1, no underrun.
//   4. R=4, div=1, one sample then s_valid_i=0: exactly 4 r_ena_o (phase 0..3),
//      then underrun_o=1 and busy_o=0.
//      Then underrun_clr_i alone -> 0; clear coinciding with a new underrun -> 1.
//   5. R=3, div=2, en_i dropped at phase 1: busy_o=0 next cycle, s_ready_o=0,
//      no r_ena_o. ratio_i changed mid-run to 5: cadence stays R=3.
//   6. ratio_i=0, div=0: behaves as R=1. Assert rst_i mid-run:
//      r_ena_o, busy_o, phase_o go 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cic_interp_scheduler.sv
// Sample-acceptance and output-cadence sequencer for the CIC interpolator datapath.
// Issues one write strobe per accepted sample and R phased read strobes per sample.
module cic_interp_scheduler #(
  parameter int unsigned RATIO_WIDTH = 4,
  parameter int unsigned DIV_WIDTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [RATIO_WIDTH-1:0] ratio_i,
  input  logic [DIV_WIDTH-1:0]   div_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic                   w_ena_o,
  output logic                   r_ena_o,
  output logic [RATIO_WIDTH-1:0] phase_o,
  output logic                   busy_o,
  output logic                   underrun_o,
  input  logic                   underrun_clr_i
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic                   loaded, loaded_nxt;
  logic [DIV_WIDTH-1:0]   div_cnt, div_cnt_nxt;
  logic [DIV_WIDTH-1:0]   div_lat, div_lat_nxt;
  logic [RATIO_WIDTH-1:0] phase, phase_nxt;
  logic [RATIO_WIDTH-1:0] r_lat, r_lat_nxt;
  logic [RATIO_WIDTH-1:0] phase_o_nxt;
  logic                   r_ena_nxt;
  logic                   underrun_nxt;

  logic                   tick;
  logic                   have_sample;
  logic                   last_phase;
  logic [RATIO_WIDTH-1:0] ratio_eff;

  // Handshake is gated by reset so nothing is accepted while the block is held.
  assign s_ready_o   = en_i & ~loaded & ~rst_i;
  assign w_ena_o     = s_valid_i & s_ready_o;
  assign busy_o      = (state == RUN);

  assign tick        = (state == RUN) && (div_cnt == div_lat);
  assign have_sample = loaded | w_ena_o;
  assign last_phase  = (phase == (r_lat - RATIO_WIDTH'(1)));
  assign ratio_eff   = (ratio_i == '0) ? RATIO_WIDTH'(1) : ratio_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      loaded     <= 1'b0;
      div_cnt    <= '0;
      div_lat    <= '0;
      phase      <= '0;
      r_lat      <= RATIO_WIDTH'(1);
      r_ena_o    <= 1'b0;
      phase_o    <= '0;
      underrun_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      loaded     <= loaded_nxt;
      div_cnt    <= div_cnt_nxt;
      div_lat    <= div_lat_nxt;
      phase      <= phase_nxt;
      r_lat      <= r_lat_nxt;
      r_ena_o    <= r_ena_nxt;
      phase_o    <= phase_o_nxt;
      underrun_o <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    loaded_nxt   = loaded | w_ena_o;
    div_cnt_nxt  = div_cnt;
    div_lat_nxt  = div_lat;
    phase_nxt    = phase;
    r_lat_nxt    = r_lat;
    r_ena_nxt    = 1'b0;
    phase_o_nxt  = phase_o;
    underrun_nxt = underrun_o & ~underrun_clr_i;

    unique case (state)
      IDLE: begin
        div_cnt_nxt = '0;
        phase_nxt   = '0;
        if (en_i && have_sample) begin
          state_nxt   = RUN;
          r_lat_nxt   = ratio_eff;
          div_lat_nxt = div_i;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_nxt   = IDLE;
          div_cnt_nxt = '0;
          phase_nxt   = '0;
        end else if (tick && (phase == '0) && !have_sample) begin
          // Starved at the start of a sample period: flag and fall back to idle.
          underrun_nxt = 1'b1;
          state_nxt    = IDLE;
          div_cnt_nxt  = '0;
          phase_nxt    = '0;
        end else if (tick) begin
          r_ena_nxt   = 1'b1;
          phase_o_nxt = phase;
          div_cnt_nxt = '0;
          if (last_phase) begin
            phase_nxt  = '0;
            loaded_nxt = 1'b0;
          end else begin
            phase_nxt = phase + RATIO_WIDTH'(1);
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!en_i) loaded_nxt = 1'b0;
  end

endmodule

// File: tb/tb_cic_interp_scheduler.sv
// Directed bench for cic_interp_scheduler: a timeline model checked every cycle,
// plus hand-computed strobe timings and phases for each scenario.
module tb_cic_interp_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] ratio;
  logic [7:0] div;
  logic       s_valid;
  logic       s_ready;
  logic       w_ena;
  logic       r_ena;
  logic [3:0] phase;
  logic       busy;
  logic       underrun;
  logic       underrun_clr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wq[$];
  int rq[$];
  int pq[$];

  cic_interp_scheduler #(.RATIO_WIDTH(4), .DIV_WIDTH(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .ratio_i        (ratio),
    .div_i          (div),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .w_ena_o        (w_ena),
    .r_ena_o        (r_ena),
    .phase_o        (phase),
    .busy_o         (busy),
    .underrun_o     (underrun),
    .underrun_clr_i (underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Timeline model: a run is a sequence of ticks every D+1 clocks; each sample covers R ticks.
  bit m_run = 0, m_loaded = 0, m_rena = 0, m_under = 0;
  int m_ph = 0, m_phase_o = 0, m_R = 1, m_D = 0, m_next_tick = 0;
  bit e_ready, e_w, have, nl, n_rena, n_under;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_w_ena", int'(w_ena), 0);
      chk("rst_r_ena", int'(r_ena), 0);
      chk("rst_phase", int'(phase), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_underrun", int'(underrun), 0);
      m_run = 0; m_loaded = 0; m_rena = 0; m_under = 0; m_ph = 0; m_phase_o = 0;
    end else begin
      e_ready = en && !m_loaded;
      e_w     = s_valid && e_ready;
      chk("s_ready", int'(s_ready), int'(e_ready));
      chk("w_ena", int'(w_ena), int'(e_w));
      chk("r_ena", int'(r_ena), int'(m_rena));
      chk("phase", int'(phase), m_phase_o);
      chk("busy", int'(busy), int'(m_run));
      chk("underrun", int'(underrun), int'(m_under));
      if (w_ena) wq.push_back(cyc);
      if (r_ena) begin rq.push_back(cyc); pq.push_back(int'(phase)); end

      have    = m_loaded || e_w;
      nl      = have;
      n_rena  = 0;
      n_under = m_under && !underrun_clr;
      if (!m_run) begin
        if (en && have) begin
          m_run = 1;
          m_R = (ratio == 0) ? 1 : int'(ratio);
          m_D = int'(div);
          m_ph = 0;
          m_next_tick = cyc + m_D + 1;
        end
      end else if (!en) begin
        m_run = 0;
      end else if (cyc == m_next_tick) begin
        if (m_ph == 0 && !have) begin
          n_under = 1;
          m_run = 0;
        end else begin
          n_rena = 1;
          m_phase_o = m_ph;
          m_next_tick = cyc + m_D + 1;
          if (m_ph == m_R - 1) begin nl = 0; m_ph = 0; end
          else m_ph++;
        end
      end
      if (!en) nl = 0;
      m_loaded = nl; m_rena = n_rena; m_under = n_under;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete(); rq.delete(); pq.delete();
  endtask

  initial begin
    bit found;
    rst = 1; en = 1; ratio = 0; div = 0; s_valid = 1; underrun_clr = 0;

    // Reset holds the handshake off even with enable and valid high.
    step(2);
    chk("t1_ready_in_rst", int'(s_ready), 0);
    chk("t1_w_in_rst", int'(w_ena), 0);
    rst = 0; en = 0;
    clear_logs();
    step(20);
    chk("t1_no_w", wq.size(), 0);
    chk("t1_no_r", rq.size(), 0);
    chk("t1_busy", int'(busy), 0);

    // R=2, div=3, continuous supply.
    clear_logs();
    ratio = 2; div = 3; en = 1;
    step(40);
    chk("t2_wq_size", int'(wq.size() >= 3), 1);
    chk("t2_rq_size", int'(rq.size() >= 4), 1);
    if (wq.size() >= 3 && rq.size() >= 4) begin
      chk("t2_r0", rq[0] - wq[0], 5);
      chk("t2_r1", rq[1] - wq[0], 9);
      chk("t2_r2", rq[2] - wq[0], 13);
      chk("t2_p0", pq[0], 0);
      chk("t2_p1", pq[1], 1);
      chk("t2_p2", pq[2], 0);
      chk("t2_p3", pq[3], 1);
      chk("t2_w1", wq[1] - wq[0], 9);
      chk("t2_w2", wq[2] - wq[1], 8);
    end
    chk("t2_underrun", int'(underrun), 0);
    en = 0;
    step(2);

    // R=1, div=0: one write and one read per clock once running.
    clear_logs();
    ratio = 1; div = 0; en = 1;
    step(12);
    @(negedge clk);
    chk("t3_w", int'(w_ena), 1);
    chk("t3_r", int'(r_ena), 1);
    chk("t3_phase", int'(phase), 0);
    chk("t3_busy", int'(busy), 1);
    chk("t3_underrun", int'(underrun), 0);
    if (wq.size() >= 2 && rq.size() >= 1) begin
      chk("t3_w_gap", wq[1] - wq[0], 2);
      chk("t3_r0", rq[0] - wq[0], 2);
    end else chk("t3_logs", 0, 1);
    step(1);
    en = 0;
    step(2);

    // R=4, div=1: a single sample yields 4 reads, then underrun.
    clear_logs();
    ratio = 4; div = 1; en = 1; s_valid = 1;
    step(1);
    s_valid = 0;
    step(20);
    chk("t4_nr", rq.size(), 4);
    for (int i = 0; i < 4; i++) if (i < pq.size()) chk("t4_phase_seq", pq[i], i);
    if (rq.size() >= 1 && wq.size() >= 1) chk("t4_r0", rq[0] - wq[0], 3);
    chk("t4_underrun", int'(underrun), 1);
    chk("t4_busy", int'(busy), 0);
    underrun_clr = 1;
    step(1);
    underrun_clr = 0;
    chk("t4_clr", int'(underrun), 0);
    s_valid = 1;
    step(1);
    s_valid = 0;
    step(9);
    chk("t4_pre_set", int'(underrun), 0);
    underrun_clr = 1;
    step(1);
    underrun_clr = 0;
    chk("t4_set_wins", int'(underrun), 1);

    // R=3, div=2 with a mid-run ratio change, then enable dropped at phase 1.
    clear_logs();
    ratio = 3; div = 2; s_valid = 1; underrun_clr = 1;
    step(1);
    underrun_clr = 0;
    step(3);
    ratio = 5;
    step(30);
    if (wq.size() >= 3 && rq.size() >= 4) begin
      chk("t5_w_period", wq[2] - wq[1], 9);
      chk("t5_r_period", rq[1] - rq[0], 3);
      chk("t5_p0", pq[0], 0);
      chk("t5_p1", pq[1], 1);
      chk("t5_p2", pq[2], 2);
      chk("t5_p3", pq[3], 0);
    end else chk("t5_logs", 0, 1);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step(1);
      if (r_ena && phase == 0) found = 1;
    end
    chk("t5_found_phase0", int'(found), 1);
    en = 0;
    step(1);
    chk("t5_busy", int'(busy), 0);
    chk("t5_ready", int'(s_ready), 0);
    clear_logs();
    step(10);
    chk("t5_no_r", rq.size(), 0);

    // ratio 0 behaves as 1; asynchronous reset mid-run.
    clear_logs();
    ratio = 0; div = 0; en = 1; s_valid = 1;
    step(8);
    @(negedge clk);
    chk("t6_r", int'(r_ena), 1);
    chk("t6_w", int'(w_ena), 1);
    chk("t6_busy", int'(busy), 1);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("t6_async_r", int'(r_ena), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_phase", int'(phase), 0);
    chk("t6_async_ready", int'(s_ready), 0);
    step(2);
    rst = 0;
    step(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
